// File: rtl/mac_array_seq.sv
// Tile sequencer for the systolic mac_array: kernel load, activation execute, drain.
// Define MAC_SEQ_PERF_EN to add the stall_cnt/busy_cnt performance counters.
module mac_array_seq #(
  parameter int col     = 8,
  parameter int row     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  num_vec,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] a_base,
  input  logic               ofifo_full,
  input  logic [col-1:0]     valid,
  output logic               mem_cen,
  output logic [addr_bw-1:0] mem_addr,
  output logic [2:0]         inst_w,
  output logic               busy,
  output logic               done
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        busy_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_DRAIN, S_FIN} state_t;

  localparam logic [len_bw-1:0] LAST_LD = len_bw'(col - 1);

  state_t             state, state_nxt;
  logic [len_bw-1:0]  nv_r, k, vcnt;
  logic [addr_bw-1:0] wb_r, ab_r;
  logic               ld_iss, ex_iss, accept;
  logic [len_bw:0]    vcnt_nxt;

  // Only the last column's valid marks a finished output vector.
  logic unused_valid;
  assign unused_valid = ^valid[col-2:0];

  assign accept = (state == S_IDLE) && start;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_FIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_iss    = 1'b0;
    ex_iss    = 1'b0;
    mem_cen   = 1'b1;
    mem_addr  = '0;
    vcnt_nxt  = {1'b0, vcnt} + (len_bw+1)'(valid[col-1]);
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        ld_iss   = 1'b1;
        mem_cen  = 1'b0;
        mem_addr = wb_r + addr_bw'(k);
        if (k == LAST_LD) state_nxt = (nv_r != '0) ? S_EXEC : S_FIN;
      end
      S_EXEC: begin
        // Address stays presented during a stall so the held k resumes cleanly.
        mem_addr = ab_r + addr_bw'(k);
        if (!ofifo_full) begin
          ex_iss  = 1'b1;
          mem_cen = 1'b0;
          if (k == nv_r - 1'b1) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (vcnt_nxt >= {1'b0, nv_r}) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // inst_w trails the issue by one cycle to line up with the SRAM read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_w <= 3'b000;
      nv_r   <= '0;
      wb_r   <= '0;
      ab_r   <= '0;
      k      <= '0;
      vcnt   <= '0;
    end else begin
      inst_w <= ld_iss ? 3'b001 : (ex_iss ? 3'b110 : 3'b000);
      if (accept) begin
        nv_r <= num_vec;
        wb_r <= w_base;
        ab_r <= a_base;
        k    <= '0;
        vcnt <= '0;
      end else begin
        if (ld_iss) k <= (k == LAST_LD) ? '0 : k + 1'b1;
        if (ex_iss) k <= k + 1'b1;
        if ((state == S_EXEC || state == S_DRAIN) && valid[col-1] && vcnt != '1)
          vcnt <= vcnt + 1'b1;
      end
    end
  end

`ifdef MAC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      busy_cnt  <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
      busy_cnt  <= '0;
    end else begin
      if (state == S_EXEC && ofifo_full && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
      if (busy && busy_cnt != 16'hFFFF) busy_cnt <= busy_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_array_seq.sv
// Scoreboard bench for mac_array_seq: expected issues are queued by stimulus, a monitor pops them.
module tb_mac_array_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_vec = '0;
  logic [10:0] w_base = '0, a_base = '0;
  logic        ofifo_full = 1'b0;
  logic [7:0]  valid;
  logic        mem_cen;
  logic [10:0] mem_addr;
  logic [2:0]  inst_w;
  logic        busy, done;
`ifdef MAC_SEQ_PERF_EN
  logic [15:0] stall_cnt, busy_cnt;
`endif

  mac_array_seq dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
    .w_base(w_base), .a_base(a_base), .ofifo_full(ofifo_full), .valid(valid),
    .mem_cen(mem_cen), .mem_addr(mem_addr), .inst_w(inst_w), .busy(busy), .done(done)
`ifdef MAC_SEQ_PERF_EN
    , .stall_cnt(stall_cnt), .busy_cnt(busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Array model: each execute instruction emerges as valid[7] ten cycles later.
  logic [9:0] vpipe;
  always @(posedge clk or negedge reset) begin
    if (!reset) vpipe <= '0;
    else        vpipe <= {vpipe[8:0], inst_w == 3'b110};
  end
  assign valid = {vpipe[9], 7'b0};

  typedef struct packed { logic [2:0] inst; logic [10:0] addr; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   n_pass = 0, n_tot = 0;
  int   exp_done = 0, cyc = 0, n110 = 0, gap = 0, cur_nv = 0;
  int   done_cyc = 0, last001 = 0, last_valid = 0;
  bit   done_seen = 0;
  logic [10:0] prev_addr = '0;
  logic        prev_cen = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
  endtask

  // Monitor: every non-zero instruction must match the head of the queue and the
  // address/enable presented one cycle earlier.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (inst_w != 3'b000) begin
        if (exp_q.size() == 0) chk("unexpected_inst", 32'(inst_w), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("inst_w", 32'(inst_w), 32'(e.inst));
          chk("mem_addr", 32'(prev_addr), 32'(e.addr));
          chk("mem_cen", 32'(prev_cen), 32'd0);
        end
      end
      if (inst_w == 3'b110) n110++;
      else if (inst_w == 3'b000 && n110 > 0 && n110 < cur_nv) gap++;
      if (inst_w == 3'b001) last001 = cyc;
      if (valid[7]) last_valid = cyc;
      if (done) begin
        chk("done_expected", 32'(exp_done > 0), 32'd1);
        if (exp_done > 0) exp_done--;
        done_cyc  = cyc;
        done_seen = 1;
      end
    end
    prev_addr = mem_addr;
    prev_cen  = mem_cen;
  end

  task automatic run_tile(input logic [10:0] wb, input logic [10:0] ab, input logic [7:0] nv,
                          input int stall_at, input int stall_len, input int restart_at);
    for (int i = 0; i < 8; i++) exp_q.push_back('{3'b001, 11'(wb + 11'(i))});
    for (int i = 0; i < int'(nv); i++) exp_q.push_back('{3'b110, 11'(ab + 11'(i))});
    exp_done++;
    cur_nv = int'(nv); n110 = 0; gap = 0; done_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; w_base = wb; a_base = ab; num_vec = nv;
    chk("busy_before_start", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int c = 1; c < 3000 && !done_seen; c++) begin
      @(posedge clk); #1;
      ofifo_full = (c >= stall_at && c < stall_at + stall_len);
      start = (c == restart_at);
      if (c == restart_at) begin a_base = 11'h3A0; num_vec = 8'd2; end
    end
    ofifo_full = 1'b0; start = 1'b0;
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    if (nv == 0) chk("done_after_last_load", 32'(done_cyc), 32'(last001));
    else         chk("done_after_last_valid", 32'(done_cyc), 32'(last_valid + 1));
    chk("exec_count", 32'(n110), 32'(nv));
    if (nv != 0) chk("bubbles", 32'(gap), 32'(stall_len));
    repeat (15) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("no_extra_done", 32'(exp_done), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_mem_cen", 32'(mem_cen), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_inst_w", 32'(inst_w), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    run_tile(11'h010, 11'h100, 8'd4, 1000, 0, -1);   // basic tile
    run_tile(11'h010, 11'h100, 8'd6, 10, 3, -1);     // three stall cycles mid-EXEC
    run_tile(11'h020, 11'h100, 8'd0, 1000, 0, -1);   // zero length
    run_tile(11'h010, 11'h100, 8'd6, 1000, 0, 10);   // start pulse mid-EXEC ignored
    run_tile(11'h040, 11'h7FE, 8'd4, 1000, 0, -1);   // 0x7FE,0x7FF,0x000,0x001

    // Asynchronous reset between edges, mid-EXEC.
    for (int i = 0; i < 8; i++) exp_q.push_back('{3'b001, 11'(11'h050 + 11'(i))});
    for (int i = 0; i < 6; i++) exp_q.push_back('{3'b110, 11'(11'h200 + 11'(i))});
    cur_nv = 6; n110 = 0; gap = 0;
    @(posedge clk); #1;
    start = 1'b1; w_base = 11'h050; a_base = 11'h200; num_vec = 8'd6;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && n110 < 2; c++) @(posedge clk);
    chk("reached_exec", 32'(n110 >= 2), 32'd1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("arst_mem_cen", 32'(mem_cen), 32'd1);
    chk("arst_inst_w", 32'(inst_w), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    exp_q.delete();
    exp_done = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (5) @(posedge clk);
    chk("post_reset_idle_busy", 32'(busy), 32'd0);
    run_tile(11'h060, 11'h300, 8'd3, 1000, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mac_array_seq.md
Name: mac_array_seq

Overview:
- Sequencer for the systolic mac_array.
- Runs one tile per start pulse: streams kernel words from SRAM into the array with kernel-load instructions, then streams activation vectors with execute instructions, then drains until every output vector has been reported valid.
- Sits between the top-level core controller and the array/SRAM.
- Stalls on output FIFO backpressure.

Parameters:
- col, 8, array columns; number of kernel-load cycles per tile.
- row, 8, array rows (informational; sizes nothing internally).
- addr_bw, 11, SRAM address width.
- len_bw, 8, width of vector-count field.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request, sampled only in IDLE.
- num_vec  input  len_bw  activation vectors this tile; latched on accepted start.
- w_base  input  addr_bw  first kernel word address; latched on start.
- a_base  input  addr_bw  first activation address; latched on start.
- ofifo_full  input  1  output FIFO cannot accept; stall issue.
- valid  input  col  array output-valid per column.
- mem_cen  output  1  SRAM chip enable, active low.
- mem_addr  output  addr_bw  SRAM read address.
- inst_w  output  3  array instruction: [2] zero north psum, [1] execute, [0] kernel load.
- busy  output  1  high in any state but IDLE.
- done  output  1  one-cycle pulse at tile completion.

Behaviour:
- Reset values, applied immediately on reset low regardless of clock: state=IDLE, mem_cen=1, mem_addr=0, inst_w=000, busy=0, done=0, all counters 0.
- States:
  - IDLE: start=1 latches inputs, goes to LOAD. start in any other state is ignored.
  - LOAD: issue col reads, addresses w_base..w_base+col-1, one per cycle, mem_cen=0. After the last issue: go to EXEC if num_vec!=0, else DONE. LOAD ignores ofifo_full.
  - EXEC: issue num_vec reads at a_base+k, k=0..num_vec-1. A cycle with ofifo_full=1 issues nothing: mem_cen=1, address held, k not advanced. After the last issue, go to DRAIN.
  - DRAIN: no issue, mem_cen=1. Count cycles with valid[col-1]=1. When the count reaches num_vec, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Valid counting runs in EXEC and DRAIN. Pulses arriving in EXEC count toward the total. A count already equal to num_vec on entry to DRAIN exits after one DRAIN cycle.
- Alignment with the 1-cycle SRAM read latency: inst_w is the registered issue code of the previous cycle.
  - Load issue → 001.
  - Execute issue → 110.
  - No issue or stalled cycle → 000.
  - Data on in_w and its instruction therefore arrive at the array in the same cycle.
- Address arithmetic wraps modulo 2^addr_bw. Counters are len_bw wide; num_vec=2^len_bw-1 is legal.
- busy rises the cycle after an accepted start and falls the cycle after DONE.
- Reset asserted mid-tile aborts the tile: no done pulse, no residual instruction.

Optional Feature:
- MAC_SEQ_PERF_EN defined: adds output stall_cnt[15:0] and output busy_cnt[15:0].
  - Both clear on accepted start.
  - stall_cnt increments on each EXEC cycle with ofifo_full=1.
  - busy_cnt increments on each busy cycle.
  - Both saturate at 16'hFFFF and hold their values in IDLE.
- Undefined: neither port nor the counters exist. Behaviour is otherwise identical.

Test Plan:
- Basic tile: col=8, w_base=0x010, a_base=0x100, num_vec=4, array model returns valid[7] four times →
  - mem_addr 0x010..0x017 with inst_w=001 one cycle later each.
  - Then 0x100..0x103 with inst_w=110.
  - done pulses once after the 4th valid, then busy=0.
- Backpressure: num_vec=6, ofifo_full high for 3 cycles during EXEC → exactly 3 inserted inst_w=000 bubbles; six 110 cycles total; addresses contiguous 0x100..0x105.
- Zero length: num_vec=0 → eight load cycles, no 110 ever, done one cycle after the last load issue.
- Start while busy: second start pulse mid-EXEC with a different a_base → ignored; the original addresses continue; only one done.
- Async reset mid-EXEC: reset low between clock edges → mem_cen=1, inst_w=000, busy=0 before the next edge; no done; a new start after release runs a full clean tile.
- Wrap: a_base=0x7FE, num_vec=4, addr_bw=11 → addresses 0x7FE, 0x7FF, 0x000, 0x001.
